// File: rtl/io_uart_fifo_port_pkg.sv
// Shared definitions for the UART FIFO port: register map indices, STAT/CTRL
// bit positions, baud presets and the TX drain state encoding.
package io_uart_fifo_port_pkg;

   // Register indices, added to BASE_ADR to form the word address.
   localparam int IDX_OUTC = 0;
   localparam int IDX_STAT = 1;
   localparam int IDX_TERM = 2;
   localparam int IDX_RXCH = 3;
   localparam int IDX_CTRL = 4;
   localparam int IDX_RXTH = 5;
   localparam int NUM_REGS = 6;

   // STAT bit positions; the two count fields sit in [15:8] and [23:16].
   localparam int STAT_TX_FULL  = 0;
   localparam int STAT_TX_EMPTY = 1;
   localparam int STAT_RX_EMPTY = 2;
   localparam int STAT_TX_OVF   = 3;
   localparam int STAT_RX_OVF   = 4;

   // CTRL bit positions.
   localparam int CTRL_TX_FLUSH = 0;
   localparam int CTRL_RX_FLUSH = 1;
   localparam int CTRL_IRQ_EN   = 2;

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_SEND = 2'd1,
      TX_HOLD = 2'd2
   } tx_state_e;

   // Baud divider term for each init_uart preset.
   function automatic logic [15:0] term_preset(input logic [1:0] sel);
      case (sel)
         2'd0:    return 16'd109;
         2'd1:    return 16'd54;
         2'd2:    return 16'd5208;
         default: return 16'd5000;
      endcase
   endfunction

   // Fit a FIFO count into an 8-bit STAT field; only a 256-deep FIFO
   // that is completely full needs the saturation.
   function automatic logic [7:0] count8(input logic [8:0] cnt);
      return cnt[8] ? 8'hFF : cnt[7:0];
   endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Synchronous FIFO with push/pop/flush, full/empty/count status and a
// combinational head output. A push into a full FIFO is accepted only when a
// pop happens in the same cycle; flush overrides both.
module io_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   // Pointer and occupancy update; pointers wrap naturally (DEPTH is a power of 2).
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_pop   = pop & ~empty & ~flush;
      do_push  = push & (~full | do_pop) & ~flush;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer/count registers.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array.
   always_ff @(posedge clk) begin
      // NOTE: the array is not reset; entries are only visible after being written.
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/io_uart_fifo_port.sv
// CPU-side UART port: TX/RX FIFOs behind the DMA/IO register window, TX drain
// FSM towards the UART core, baud term register and RX interrupt.
// Optional feature macro: UART_RX_THRESH_EN adds the RXTH register and the
// uart_rx_irq_lvl level interrupt output.
module io_uart_fifo_port
   import io_uart_fifo_port_pkg::*;
#(
   parameter int          TX_DEPTH = 16,
   parameter int          RX_DEPTH = 16,
   parameter logic [13:0] BASE_ADR = 14'h3F00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dma_io_we,
   input  logic [13:0] dma_io_wadr,
   input  logic [31:0] dma_io_wdata,
   input  logic [13:0] dma_io_radr,
   input  logic        dma_io_radr_en,
   input  logic [31:0] dma_io_rdata_in,
   output logic [31:0] dma_io_rdata,
   output logic [7:0]  uart_io_char,
   output logic        uart_io_we,
   input  logic        uart_io_full,
   input  logic [1:0]  init_uart,
   output logic [15:0] uart_term,
   input  logic        cpu_run_state,
   input  logic        rout_en,
   input  logic [7:0]  rout,
   output logic        ext_uart_interrpt_1shot
`ifdef UART_RX_THRESH_EN
   ,
   output logic        uart_rx_irq_lvl
`endif
);

   localparam int TCW = $clog2(TX_DEPTH) + 1;
   localparam int RCW = $clog2(RX_DEPTH) + 1;

   logic [NUM_REGS-1:0] wr_sel, rd_sel, sel_q, sel_d;
   logic [31:0]         rd_data_q, rd_data_d, stat;
   logic                tx_push, tx_pop, tx_flush, tx_full, tx_empty;
   logic                rx_push, rx_pop, rx_flush, rx_full, rx_empty;
   logic [7:0]          tx_head, rx_head;
   logic [TCW-1:0]      tx_count;
   logic [RCW-1:0]      rx_count;
   logic                tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
   logic                rx_irq_en_q, rx_irq_en_d;
   logic [7:0]          last_tx_q, last_tx_d;
   logic [15:0]         term_q, term_d;
   logic [1:0]          init_cnt_q, init_cnt_d;
   tx_state_e           state_q, state_d;
   logic [7:0]          uart_char_q, uart_char_d;
   logic                uart_we_q, uart_we_d;
   logic                unused_wdata;
`ifdef UART_RX_THRESH_EN
   logic [7:0]          rxth_q, rxth_d;
`endif

   assign unused_wdata = ^dma_io_wdata[31:16];

   // Address decode for both bus directions.
   always_comb begin
      wr_sel = '0;
      rd_sel = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         wr_sel[i] = dma_io_we      & (dma_io_wadr == BASE_ADR + 14'(i));
         rd_sel[i] = dma_io_radr_en & (dma_io_radr == BASE_ADR + 14'(i));
      end
`ifndef UART_RX_THRESH_EN
      wr_sel[IDX_RXTH] = 1'b0;
      rd_sel[IDX_RXTH] = 1'b0;
`endif
   end

   assign tx_push = wr_sel[IDX_OUTC];
   assign rx_push = cpu_run_state & rout_en;
   assign rx_pop  = rd_sel[IDX_RXCH];

   io_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push),
      .pop   (tx_pop),
      .flush (tx_flush),
      .wdata (dma_io_wdata[7:0]),
      .rdata (tx_head),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count)
   );

   io_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_push),
      .pop   (rx_pop),
      .flush (rx_flush),
      .wdata (rout),
      .rdata (rx_head),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count)
   );

   // Control/status next-state: flushes, overflow flags, CTRL, TERM, last TX char.
   always_comb begin
      tx_flush    = wr_sel[IDX_CTRL] & dma_io_wdata[CTRL_TX_FLUSH];
      rx_flush    = wr_sel[IDX_CTRL] & dma_io_wdata[CTRL_RX_FLUSH];
      // A set in the same cycle as a STAT read wins over the clear.
      tx_ovf_d    = (tx_push & tx_full & ~tx_pop & ~tx_flush)
                  | (tx_ovf_q & ~rd_sel[IDX_STAT]);
      rx_ovf_d    = (rx_push & rx_full & ~(rx_pop & ~rx_empty) & ~rx_flush)
                  | (rx_ovf_q & ~rd_sel[IDX_STAT]);
      rx_irq_en_d = wr_sel[IDX_CTRL] ? dma_io_wdata[CTRL_IRQ_EN] : rx_irq_en_q;
      last_tx_d   = (tx_push & (~tx_full | tx_pop) & ~tx_flush) ? dma_io_wdata[7:0] : last_tx_q;
      init_cnt_d  = (init_cnt_q == 2'd2) ? init_cnt_q : init_cnt_q + 2'd1;
      term_d      = term_q;
      if (init_cnt_q == 2'd1) term_d = term_preset(init_uart);
      if (wr_sel[IDX_TERM])   term_d = dma_io_wdata[15:0];
`ifdef UART_RX_THRESH_EN
      rxth_d      = wr_sel[IDX_RXTH] ? dma_io_wdata[7:0] : rxth_q;
`endif
   end

   // Control/status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_ovf_q    <= 1'b0;
         rx_ovf_q    <= 1'b0;
         rx_irq_en_q <= 1'b0;
         last_tx_q   <= '0;
         init_cnt_q  <= '0;
         term_q      <= '0;
`ifdef UART_RX_THRESH_EN
         rxth_q      <= 8'd1;
`endif
      end else begin
         tx_ovf_q    <= tx_ovf_d;
         rx_ovf_q    <= rx_ovf_d;
         rx_irq_en_q <= rx_irq_en_d;
         last_tx_q   <= last_tx_d;
         init_cnt_q  <= init_cnt_d;
         term_q      <= term_d;
`ifdef UART_RX_THRESH_EN
         rxth_q      <= rxth_d;
`endif
      end
   end

   // TX drain decisions: the pop and the char capture happen on entry to SEND,
   // HOLD gives the core one cycle to raise uart_io_full.
   always_comb begin
      state_d     = state_q;
      uart_char_d = uart_char_q;
      uart_we_d   = 1'b0;
      tx_pop      = 1'b0;
      case (state_q)
         TX_IDLE: begin
            if (~tx_empty & ~uart_io_full & ~tx_flush) begin
               tx_pop      = 1'b1;
               uart_char_d = tx_head;
               uart_we_d   = 1'b1;
               state_d     = TX_SEND;
            end
         end
         TX_SEND: state_d = TX_HOLD;
         TX_HOLD: state_d = TX_IDLE;
         default: state_d = TX_IDLE;
      endcase
   end

   // TX drain FSM state and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= TX_IDLE;
         uart_char_q <= '0;
         uart_we_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         uart_char_q <= uart_char_d;
         uart_we_q   <= uart_we_d;
      end
   end

   // Read mux: capture the addressed register on the strobe cycle.
   always_comb begin
      stat                 = '0;
      stat[STAT_TX_FULL]   = tx_full;
      stat[STAT_TX_EMPTY]  = tx_empty;
      stat[STAT_RX_EMPTY]  = rx_empty;
      stat[STAT_TX_OVF]    = tx_ovf_q;
      stat[STAT_RX_OVF]    = rx_ovf_q;
      stat[15:8]           = count8(9'(tx_count));
      stat[23:16]          = count8(9'(rx_count));
      sel_d                = rd_sel;
      rd_data_d            = '0;
      if (rd_sel[IDX_OUTC]) rd_data_d = {24'd0, last_tx_q};
      if (rd_sel[IDX_STAT]) rd_data_d = stat;
      if (rd_sel[IDX_TERM]) rd_data_d = {16'd0, term_q};
      if (rd_sel[IDX_RXCH]) rd_data_d = {22'd0, rx_ovf_q, ~rx_empty, rx_empty ? 8'd0 : rx_head};
      if (rd_sel[IDX_CTRL]) rd_data_d = {29'd0, rx_irq_en_q, 2'b00};
`ifdef UART_RX_THRESH_EN
      if (rd_sel[IDX_RXTH]) rd_data_d = {24'd0, rxth_q};
`endif
   end

   // Read data/select registers; an empty select passes the daisy chain through.
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q     <= '0;
         rd_data_q <= '0;
      end else begin
         sel_q     <= sel_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign dma_io_rdata            = (|sel_q) ? rd_data_q : dma_io_rdata_in;
   assign uart_io_char            = uart_char_q;
   assign uart_io_we              = uart_we_q;
   assign uart_term               = term_q;
   assign ext_uart_interrpt_1shot = cpu_run_state & rout_en & rx_irq_en_q;
`ifdef UART_RX_THRESH_EN
   assign uart_rx_irq_lvl = rx_irq_en_q & (rxth_q != 8'd0) & (9'(rx_count) >= 9'(rxth_q));
`endif

endmodule
